// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer for the execute stage: shift-add multiply,
// restoring divide, one iteration per cycle, pipeline stall until done.
module ex_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [4:0]      ern0,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] md_res,
  output logic [4:0]      md_rn
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic [4:0]       rn_q, md_rn_q;
  logic [XLEN-1:0]  b_q, hi_q, lo_q, res_q, md_res_q;
  logic             neg_q;

  // operand decode at accept
  logic            is_div, signed_a, signed_b, sa, sb, neg_in;
  logic            div_zero, ovf, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    is_div   = funct3[2];
    signed_a = is_div ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    signed_b = is_div ? !funct3[0] : (funct3[1:0] == 2'b01);
    sa       = signed_a & ea[XLEN-1];
    sb       = signed_b & eb[XLEN-1];
    a_mag    = sa ? -ea : ea;
    b_mag    = sb ? -eb : eb;
    // remainder takes the dividend sign; everything else the product of signs
    neg_in   = (is_div && funct3[1]) ? sa : (sa ^ sb);
    div_zero = is_div && (eb == '0);
    ovf      = is_div && !funct3[0] && (ea == MIN_INT) && (eb == '1);
    special  = div_zero || ovf;
    if (div_zero) spec_res = funct3[1] ? ea : '1;
    else          spec_res = funct3[1] ? '0 : ea;
    accept   = (state_q == IDLE) && start && !kill;
  end

  // one iteration: hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n, fin;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    if (op_q[2]) begin
      if (op_q[1]) fin = neg_q ? -hi_n : hi_n;
      else         fin = neg_q ? -lo_n : lo_n;
    end else begin
      fin = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = special ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rn_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
      md_res_q <= '0;
      md_rn_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= funct3;
        rn_q  <= ern0;
        b_q   <= b_mag;
        hi_q  <= '0;
        lo_q  <= a_mag;
        neg_q <= neg_in;
        cnt_q <= CNT_W'(XLEN-1);
        if (special) res_q <= spec_res;
      end else if (state_q == CALC && !kill) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == '0) res_q <= fin;
      end
      if (done) begin
        md_res_q <= res_q;
        md_rn_q  <= rn_q;
      end
    end
  end

  // Result is shown live during DONE but only committed to the holding
  // register when DONE completes unkilled.
  assign busy   = (state_q == CALC);
  assign done   = (state_q == DONE) && !kill;
  assign stall  = start && !done && !kill;
  assign md_res = done ? res_q : md_res_q;
  assign md_rn  = done ? rn_q  : md_rn_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: results, latency, specials, kill, reset,
// back-to-back issue.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, kill;
  logic [2:0]  funct3;
  logic [31:0] ea, eb;
  logic [4:0]  ern0;
  logic        stall, busy, done;
  logic [31:0] md_res;
  logic [4:0]  md_rn;

  int total = 0;
  int bad   = 0;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .ea(ea), .eb(eb), .ern0(ern0), .stall(stall), .busy(busy), .done(done),
    .md_res(md_res), .md_rn(md_rn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Current cycle is cycle 0 (accept). Operands are scrambled from cycle 1 on.
  task automatic wait_done(input string tag, input logic [31:0] exp_res,
                           input logic [4:0] exp_rn, input int exp_lat);
    int  cyc;
    int  stall_miss;
    bit  seen;
    cyc = 0; stall_miss = 0; seen = 0;
    while (!seen && cyc <= 40) begin
      #1;
      if (done === 1'b1) seen = 1;
      else begin
        if (stall !== 1'b1) stall_miss++;
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          ea = 32'hDEAD_BEEF; eb = 32'h0; ern0 = 5'd31;
        end
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_stall_busy"}, 32'(stall_miss), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_res"}, md_res, exp_res);
    chk({tag, "_rn"}, 32'(md_rn), 32'(exp_rn));
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rn);
    start = 1'b1; funct3 = f3; ea = a; eb = b; ern0 = rn;
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rn,
                        input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk);
    issue(f3, a, b, rn);
    wait_done(tag, exp_res, rn, exp_lat);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({tag, "_after_done"}, 32'(done), 32'd0);
    chk({tag, "_hold_res"}, md_res, exp_res);
    chk({tag, "_hold_rn"}, 32'(md_rn), 32'(rn));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    funct3 = 3'd0; ea = '0; eb = '0; ern0 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_res", md_res, 32'd0);
    chk("rst_rn", 32'(md_rn), 32'd0);
    rst_n = 1'b1;

    run_op("mul_7x6",    3'b000, 32'd7,          32'd6,          5'd1, 32'd42,          33);
    run_op("mul_neg",    3'b000, 32'hFFFF_FFFD,  32'd5,          5'd2, 32'hFFFF_FFF1,   33);
    run_op("mulh_m1",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd3, 32'h0000_0000,   33);
    run_op("mulhu_m1",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd4, 32'hFFFF_FFFE,   33);
    run_op("mulhsu_m1",  3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5, 32'hFFFF_FFFF,   33);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6, 32'hFFFF_FFFD,   33);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9,  32'd2,          5'd7, 32'hFFFF_FFFF,   33);
    run_op("div_7_m2",   3'b100, 32'd7,          32'hFFFF_FFFE,  5'd8, 32'hFFFF_FFFD,   33);
    run_op("rem_7_m2",   3'b110, 32'd7,          32'hFFFF_FFFE,  5'd9, 32'd1,           33);
    run_op("divu_100_7", 3'b101, 32'd100,        32'd7,          5'd10, 32'd14,         33);
    run_op("remu_100_7", 3'b111, 32'd100,        32'd7,          5'd11, 32'd2,          33);
    run_op("div_by0",    3'b100, 32'd5,          32'd0,          5'd12, 32'hFFFF_FFFF,  1);
    run_op("rem_by0",    3'b110, 32'd5,          32'd0,          5'd13, 32'd5,          1);
    run_op("divu_by0",   3'b101, 32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1);
    run_op("div_ovf",    3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          1);

    // kill in CALC cycle 10, start held -> re-accepted next cycle
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 5'd20);
    repeat (10) @(negedge clk);
    #1;
    chk("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    #1;
    chk("kill_done", 32'(done), 32'd0);
    chk("kill_stall", 32'(stall), 32'd0);
    chk("kill_res_kept", md_res, 32'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    chk("kill_idle", 32'(busy), 32'd0);
    chk("kill_rn_kept", 32'(md_rn), 32'd16);
    ea = 32'd3; eb = 32'd4; ern0 = 5'd20;
    wait_done("kill_reacc", 32'd12, 5'd20, 33);
    @(negedge clk);
    start = 1'b0;

    // reset in CALC cycle 5
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    repeat (5) @(negedge clk);
    #1;
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_res", md_res, 32'd0);
    chk("rstmid_rn", 32'(md_rn), 32'd0);
    rst_n = 1'b1;

    // back-to-back: second op accepted in the cycle after DONE
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    wait_done("b2b_first", 32'd14, 5'd3, 33);
    @(negedge clk);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    wait_done("b2b_second", 32'hFFFF_FFFD, 5'd4, 33);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("b2b_hold_res", md_res, 32'hFFFF_FFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
